// File: rtl/fifo_rd_gen_if.sv
// Read-side port bundle of the asynchronous FIFO read-pointer generator.
//   slave  : seen by fifo_rd_gen (takes read requests and the synchronised
//            write pointer, returns pointer, address and status).
//   master : seen by whoever drives read requests (consumer / testbench).
// Signals:
//   R_EN            read request
//   R_FLUSH         discard all unread words
//   RQ2_W_PTR       Gray write pointer, already synchronised into the read clock
//   R_PTR           registered Gray read pointer for the write domain
//   R_ADDR          RAM read address
//   R_EMPTY         FIFO empty (registered)
//   R_ALMOST_EMPTY  level at or below the almost-empty threshold (registered)
//   R_LEVEL         number of readable words (combinational)
//   R_UNDERFLOW     one-cycle pulse after a rejected read
interface fifo_rd_gen_if #(
  parameter int PTR_SIZE   = 4,
  parameter int ADDR_WIDTH = 3
);
  logic                  R_EN;
  logic                  R_FLUSH;
  logic [PTR_SIZE-1:0]   RQ2_W_PTR;
  logic [PTR_SIZE-1:0]   R_PTR;
  logic [ADDR_WIDTH-1:0] R_ADDR;
  logic                  R_EMPTY;
  logic                  R_ALMOST_EMPTY;
  logic [PTR_SIZE-1:0]   R_LEVEL;
  logic                  R_UNDERFLOW;

  modport master (
    output R_EN, R_FLUSH, RQ2_W_PTR,
    input  R_PTR, R_ADDR, R_EMPTY, R_ALMOST_EMPTY, R_LEVEL, R_UNDERFLOW
  );

  modport slave (
    input  R_EN, R_FLUSH, RQ2_W_PTR,
    output R_PTR, R_ADDR, R_EMPTY, R_ALMOST_EMPTY, R_LEVEL, R_UNDERFLOW
  );
endinterface

// File: rtl/fifo_rd_gen.sv
// Read-domain pointer generator of an asynchronous FIFO.
// Keeps a binary read pointer, hands the RAM its read address, publishes a
// glitch-free Gray pointer to the write domain and derives empty /
// almost-empty / level / underflow status from the synchronised write pointer.
// Ports:
//   R_CLK  read-domain clock (only clock)
//   R_RST  synchronous active-high reset
//   rd     fifo_rd_gen_if.slave bundle (see the interface file for signals)
module fifo_rd_gen #(
  parameter int MEM_DEPTH  = 8,
  parameter int PTR_SIZE   = $clog2(MEM_DEPTH) + 1,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int AE_THRESH  = 1
) (
  input  logic         R_CLK,
  input  logic         R_RST,
  fifo_rd_gen_if.slave rd
);

  localparam logic [PTR_SIZE-1:0] AE_LIMIT = PTR_SIZE'(AE_THRESH);
  localparam logic [PTR_SIZE-1:0] PTR_ONE  = PTR_SIZE'(1);

  // Binary to Gray, any width.
  function automatic logic [PTR_SIZE-1:0] bin2gray(input logic [PTR_SIZE-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary by prefix XOR from the MSB downwards, any width.
  function automatic logic [PTR_SIZE-1:0] gray2bin(input logic [PTR_SIZE-1:0] g);
    logic [PTR_SIZE-1:0] b;
    b[PTR_SIZE-1] = g[PTR_SIZE-1];
    for (int i = PTR_SIZE - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_SIZE-1:0] rbin_q, rbin_d;
  logic [PTR_SIZE-1:0] r_ptr_q, r_ptr_d;
  logic                empty_q, empty_d;
  logic                almost_empty_q, almost_empty_d;
  logic                underflow_q, underflow_d;

  logic [PTR_SIZE-1:0] wbin_s;
  logic [PTR_SIZE-1:0] gray_next_s;
  logic [PTR_SIZE-1:0] level_next_s;
  logic                rd_accept_s;

  // Next-state of the read pointer and the registered status flags.
  always_comb begin
    wbin_s       = gray2bin(rd.RQ2_W_PTR);
    // Flush wins over a read; a read is only taken while not registered-empty.
    rd_accept_s  = rd.R_EN & ~empty_q & ~rd.R_FLUSH;

    if (rd.R_FLUSH) begin
      rbin_d = wbin_s;
    end else if (rd_accept_s) begin
      rbin_d = rbin_q + PTR_ONE;
    end else begin
      rbin_d = rbin_q;
    end

    gray_next_s  = bin2gray(rbin_d);
    level_next_s = wbin_s - rbin_d;

    if (rd.R_FLUSH) begin
      r_ptr_d        = rd.RQ2_W_PTR;
      empty_d        = 1'b1;
      almost_empty_d = 1'b1;
      underflow_d    = 1'b0;
    end else begin
      r_ptr_d        = gray_next_s;
      // Full compare including the wrap bit, so a full FIFO is not empty.
      empty_d        = (gray_next_s == rd.RQ2_W_PTR);
      almost_empty_d = (level_next_s <= AE_LIMIT);
      underflow_d    = rd.R_EN & empty_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      rbin_q         <= {PTR_SIZE{1'b0}};
      r_ptr_q        <= {PTR_SIZE{1'b0}};
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      underflow_q    <= 1'b0;
    end else begin
      rbin_q         <= rbin_d;
      r_ptr_q        <= r_ptr_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      underflow_q    <= underflow_d;
    end
  end

  assign rd.R_PTR          = r_ptr_q;
  assign rd.R_ADDR         = rbin_q[ADDR_WIDTH-1:0];
  assign rd.R_EMPTY        = empty_q;
  assign rd.R_ALMOST_EMPTY = almost_empty_q;
  // Level tracks the live write pointer, so it is deliberately combinational.
  assign rd.R_LEVEL        = gray2bin(rd.RQ2_W_PTR) - rbin_q;
  assign rd.R_UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_fifo_rd_gen.sv
module tb_fifo_rd_gen;

  localparam int MEM_DEPTH  = 8;
  localparam int PTR_SIZE   = 4;
  localparam int ADDR_WIDTH = 3;

  logic clk;
  logic rst;

  fifo_rd_gen_if #(.PTR_SIZE(PTR_SIZE), .ADDR_WIDTH(ADDR_WIDTH)) rd_if ();

  fifo_rd_gen #(
    .MEM_DEPTH (MEM_DEPTH),
    .PTR_SIZE  (PTR_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH),
    .AE_THRESH (1)
  ) dut (
    .R_CLK(clk),
    .R_RST(rst),
    .rd   (rd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string    name;
    bit [3:0] ptr;
    bit [2:0] addr;
    bit       empty;
    bit       ae;
    bit [3:0] level;
    bit       uf;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic chk(input string name, input string field, input int act, input int req);
    tests_run++;
    if (act != req) begin
      tests_failed++;
      $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, req);
    end
  endtask

  // Monitor: after each active edge, pop one expectation and compare all outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "R_PTR",          int'(rd_if.R_PTR),          int'(e.ptr));
      chk(e.name, "R_ADDR",         int'(rd_if.R_ADDR),         int'(e.addr));
      chk(e.name, "R_EMPTY",        int'(rd_if.R_EMPTY),        int'(e.empty));
      chk(e.name, "R_ALMOST_EMPTY", int'(rd_if.R_ALMOST_EMPTY), int'(e.ae));
      chk(e.name, "R_LEVEL",        int'(rd_if.R_LEVEL),        int'(e.level));
      chk(e.name, "R_UNDERFLOW",    int'(rd_if.R_UNDERFLOW),    int'(e.uf));
    end
  end

  // Apply one cycle of stimulus and queue the hand-computed post-edge outputs.
  task automatic step(input bit r, input bit en, input bit fl, input bit [3:0] wp,
                      input bit [3:0] ptr, input bit [2:0] addr, input bit empty,
                      input bit ae, input bit [3:0] level, input bit uf,
                      input string name);
    exp_t e;
    rst             = r;
    rd_if.R_EN      = en;
    rd_if.R_FLUSH   = fl;
    rd_if.RQ2_W_PTR = wp;
    e.name = name; e.ptr = ptr; e.addr = addr; e.empty = empty;
    e.ae = ae; e.level = level; e.uf = uf;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    rd_if.R_EN      = 1'b0;
    rd_if.R_FLUSH   = 1'b0;
    rd_if.RQ2_W_PTR = 4'b0000;
    @(negedge clk);
    #1;

    //    rst  en   fl   wptr     ptr      addr  emp  ae   lvl    uf
    // Reset held for two edges
    step(1'b1,1'b0,1'b0,4'b0000, 4'b0000,3'd0,1'b1,1'b1,4'd0,1'b0,"rst1");
    step(1'b1,1'b0,1'b0,4'b0000, 4'b0000,3'd0,1'b1,1'b1,4'd0,1'b0,"rst2");
    // Drain: write pointer at 3, then three reads
    step(1'b0,1'b0,1'b0,4'b0010, 4'b0000,3'd0,1'b0,1'b0,4'd3,1'b0,"drain_idle");
    step(1'b0,1'b1,1'b0,4'b0010, 4'b0001,3'd1,1'b0,1'b0,4'd2,1'b0,"drain_rd1");
    step(1'b0,1'b1,1'b0,4'b0010, 4'b0011,3'd2,1'b0,1'b1,4'd1,1'b0,"drain_rd2");
    step(1'b0,1'b1,1'b0,4'b0010, 4'b0010,3'd3,1'b1,1'b1,4'd0,1'b0,"drain_rd3");
    // Underflow: keep reading while empty
    step(1'b0,1'b1,1'b0,4'b0010, 4'b0010,3'd3,1'b1,1'b1,4'd0,1'b1,"uf1");
    step(1'b0,1'b1,1'b0,4'b0010, 4'b0010,3'd3,1'b1,1'b1,4'd0,1'b1,"uf2");
    step(1'b0,1'b0,1'b0,4'b0010, 4'b0010,3'd3,1'b1,1'b1,4'd0,1'b0,"uf_clear");
    // Wrap / full: reset, write pointer at 8, then 8 reads
    step(1'b1,1'b0,1'b0,4'b0000, 4'b0000,3'd0,1'b1,1'b1,4'd0,1'b0,"rst3");
    step(1'b0,1'b0,1'b0,4'b1100, 4'b0000,3'd0,1'b0,1'b0,4'd8,1'b0,"full");
    step(1'b0,1'b1,1'b0,4'b1100, 4'b0001,3'd1,1'b0,1'b0,4'd7,1'b0,"wrap_rd1");
    step(1'b0,1'b1,1'b0,4'b1100, 4'b0011,3'd2,1'b0,1'b0,4'd6,1'b0,"wrap_rd2");
    step(1'b0,1'b1,1'b0,4'b1100, 4'b0010,3'd3,1'b0,1'b0,4'd5,1'b0,"wrap_rd3");
    step(1'b0,1'b1,1'b0,4'b1100, 4'b0110,3'd4,1'b0,1'b0,4'd4,1'b0,"wrap_rd4");
    step(1'b0,1'b1,1'b0,4'b1100, 4'b0111,3'd5,1'b0,1'b0,4'd3,1'b0,"wrap_rd5");
    step(1'b0,1'b1,1'b0,4'b1100, 4'b0101,3'd6,1'b0,1'b0,4'd2,1'b0,"wrap_rd6");
    step(1'b0,1'b1,1'b0,4'b1100, 4'b0100,3'd7,1'b0,1'b1,4'd1,1'b0,"wrap_rd7");
    step(1'b0,1'b1,1'b0,4'b1100, 4'b1100,3'd0,1'b1,1'b1,4'd0,1'b0,"wrap_rd8");
    // Flush: write pointer at 13 (Gray 1011) gives level 5, then flush with R_EN
    step(1'b0,1'b0,1'b0,4'b1011, 4'b1100,3'd0,1'b0,1'b0,4'd5,1'b0,"lvl5");
    step(1'b0,1'b1,1'b1,4'b1011, 4'b1011,3'd5,1'b1,1'b1,4'd0,1'b0,"flush");
    step(1'b0,1'b1,1'b0,4'b1011, 4'b1011,3'd5,1'b1,1'b1,4'd0,1'b1,"post_flush_uf");
    // Mid-burst reset: write pointer at 7 (Gray 0100), read to RBIN=5, reset with R_EN high
    step(1'b1,1'b0,1'b0,4'b0000, 4'b0000,3'd0,1'b1,1'b1,4'd0,1'b0,"rst4");
    step(1'b0,1'b0,1'b0,4'b0100, 4'b0000,3'd0,1'b0,1'b0,4'd7,1'b0,"burst_idle");
    step(1'b0,1'b1,1'b0,4'b0100, 4'b0001,3'd1,1'b0,1'b0,4'd6,1'b0,"burst_rd1");
    step(1'b0,1'b1,1'b0,4'b0100, 4'b0011,3'd2,1'b0,1'b0,4'd5,1'b0,"burst_rd2");
    step(1'b0,1'b1,1'b0,4'b0100, 4'b0010,3'd3,1'b0,1'b0,4'd4,1'b0,"burst_rd3");
    step(1'b0,1'b1,1'b0,4'b0100, 4'b0110,3'd4,1'b0,1'b0,4'd3,1'b0,"burst_rd4");
    step(1'b0,1'b1,1'b0,4'b0100, 4'b0111,3'd5,1'b0,1'b0,4'd2,1'b0,"burst_rd5");
    step(1'b1,1'b1,1'b1,4'b0100, 4'b0000,3'd0,1'b1,1'b1,4'd7,1'b0,"mid_rst");
    // After reset R_EMPTY is still 1 for one edge, so the first R_EN underflows
    step(1'b0,1'b1,1'b0,4'b0100, 4'b0000,3'd0,1'b0,1'b0,4'd7,1'b1,"post_rst_uf");
    step(1'b0,1'b1,1'b0,4'b0100, 4'b0001,3'd1,1'b0,1'b0,4'd6,1'b0,"post_rst_rd1");

    rd_if.R_EN = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_queue: %0d expectations left, expected 0", exp_q.size());
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
